qs_srt_fetch: RTL and testbench

//  Instruction fetch stage for the quicksort microsequencer.
//  - Owns the program counter and drives the address of the combinational microcode ROM.
//  - Registers the returned instruction and its PC into a single-entry output register.
//  - Presents that register to decode/execute with a valid/ready handshake.
//  - Accepts control-flow redirects (J/Jcc taken, CALL, RET) back from execute.
//

---
 rtl/qs_srt_fetch.sv | 112 +++++++++++
 tb/tb_qs_srt_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qs_srt_fetch.sv
// qs_srt_fetch
//   Instruction fetch stage for the quicksort microsequencer. Owns the
//   program counter, addresses a zero-latency microcode ROM, and captures the
//   returned instruction (with its PC) into a single-entry output register
//   that decode/execute drains through a valid/ready handshake. Execute can
//   redirect the PC at any time after the first fetch; a redirect squashes any
//   held instruction and inserts one bubble cycle before the target loads.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   fetch_en          permit new fetches (0 freezes PC; register still drains)
//   rom_ra/rom_rout   ROM address (= PC) and combinational instruction return
//   dec_vld/dec_inst/dec_pc/dec_rdy   output register and handshake
//   redirect_vld/redirect_pc          control-flow change from execute
//   stat_redirect     saturating count of redirects taken
module qs_srt_fetch #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [PC_W-1:0]   rom_ra,
  input  logic [INST_W-1:0] rom_rout,
  output logic              dec_vld,
  output logic [INST_W-1:0] dec_inst,
  output logic [PC_W-1:0]   dec_pc,
  input  logic              dec_rdy,
  input  logic              redirect_vld,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [15:0]       stat_redirect
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic              vld_reg, vld_next;
  logic [INST_W-1:0] inst_reg, inst_next;
  logic [PC_W-1:0]   dpc_reg, dpc_next;
  logic [15:0]       stat_reg, stat_next;

  logic take_redirect;
  logic load;

  // A redirect is meaningless before the first fetch, so IDLE ignores it.
  assign take_redirect = redirect_vld & (state_reg != IDLE);

  // Redirect in the same cycle blocks the load even when it is ignored in
  // IDLE; the REDIR bubble never loads so the target settles on rom_ra.
  assign load = fetch_en & (~vld_reg | dec_rdy) & ~redirect_vld & (state_reg != REDIR);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    vld_next   = vld_reg;
    inst_next  = inst_reg;
    dpc_next   = dpc_reg;
    stat_next  = stat_reg;

    unique case (state_reg)
      IDLE:    if (fetch_en) state_next = RUN;
      RUN:     if (take_redirect) state_next = REDIR;
      REDIR:   state_next = take_redirect ? REDIR : RUN;
      default: state_next = IDLE;
    endcase

    if (take_redirect) begin
      // Squashes any held instruction; an accepted one has already gone.
      pc_next  = redirect_pc;
      vld_next = 1'b0;
      if (stat_reg != 16'hFFFF) stat_next = stat_reg + 16'd1;
    end else if (load) begin
      inst_next = rom_rout;
      dpc_next  = pc_reg;
      vld_next  = 1'b1;
      pc_next   = pc_reg + PC_W'(1);
    end else if (vld_reg & dec_rdy) begin
      vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      vld_reg   <= 1'b0;
      inst_reg  <= '0;
      dpc_reg   <= '0;
      stat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      vld_reg   <= vld_next;
      inst_reg  <= inst_next;
      dpc_reg   <= dpc_next;
      stat_reg  <= stat_next;
    end
  end

  assign rom_ra        = pc_reg;
  assign dec_vld       = vld_reg;
  assign dec_inst      = inst_reg;
  assign dec_pc        = dpc_reg;
  assign stat_redirect = stat_reg;

endmodule

// File: tb/tb_qs_srt_fetch.sv
// tb_qs_srt_fetch
//   Self-checking bench for qs_srt_fetch: directed scenarios for streaming,
//   stall, redirect, squash, PC wrap and reset during a bubble, followed by a
//   randomized run compared cycle by cycle against a behavioural model.
module tb_qs_srt_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [7:0]  rom_ra;
  logic [15:0] rom_rout;
  logic        dec_vld;
  logic [15:0] dec_inst;
  logic [7:0]  dec_pc;
  logic        dec_rdy = 1'b0;
  logic        redirect_vld = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [15:0] stat_redirect;

  logic [15:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of what the consumer should see.
  logic [7:0]  m_pc;       // next address to fetch
  logic        m_vld;
  logic [15:0] m_inst;
  logic [7:0]  m_dpc;
  logic [15:0] m_cnt;
  logic        m_started;  // has fetching ever been enabled since reset
  logic        m_bubble;   // one dead cycle after a redirect

  always #5 clk = ~clk;

  assign rom_rout = rom[rom_ra];

  qs_srt_fetch #(.PC_W(8), .INST_W(16), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .rom_ra(rom_ra), .rom_rout(rom_rout),
    .dec_vld(dec_vld), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_rdy(dec_rdy),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .stat_redirect(stat_redirect)
  );

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    logic       r, fe, rdy, rv;
    logic [7:0] rp;
    r = rst; fe = fetch_en; rdy = dec_rdy; rv = redirect_vld; rp = redirect_pc;
    @(posedge clk);
    if (r) begin
      m_pc = 8'd0; m_vld = 1'b0; m_inst = 16'd0; m_dpc = 8'd0;
      m_cnt = 16'd0; m_started = 1'b0; m_bubble = 1'b0;
    end else if (rv && m_started) begin
      m_pc = rp; m_vld = 1'b0; m_bubble = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else begin
      if (fe && (!m_vld || rdy) && !rv) begin
        m_inst = rom[m_pc]; m_dpc = m_pc; m_vld = 1'b1; m_pc = m_pc + 8'd1;
      end else if (m_vld && rdy) begin
        m_vld = 1'b0;
      end
      if (fe) m_started = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; dec_rdy = 1'b0; redirect_vld = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %0b want 0", dec_vld); end
    n_checks++; if (dec_pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", dec_pc); end
    n_checks++; if (dec_inst !== 16'd0) begin n_fail++; $display("FAIL reset_inst: got %0h want 0", dec_inst); end
    n_checks++; if (stat_redirect !== 16'd0) begin n_fail++; $display("FAIL reset_stat: got %0h want 0", stat_redirect); end
    n_checks++; if (rom_ra !== 8'd0) begin n_fail++; $display("FAIL reset_ra: got %0h want 0", rom_ra); end
    step(); // IDLE with fetch_en=0 must not fetch
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL idle_vld: got %0b want 0", dec_vld); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    fetch_en = 1'b1; dec_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'(i) || dec_inst !== rom[i]) begin
        n_fail++; $display("FAIL stream_%0d: got vld=%0b pc=%0h inst=%0h want vld=1 pc=%0h inst=%0h",
                           i, dec_vld, dec_pc, dec_inst, i, rom[i]);
      end
    end
    $display("test_stream done");
  endtask

  task automatic test_stall();
    step(); step(); // dec_pc 4, 5
    n_checks++; if (dec_pc !== 8'd5) begin n_fail++; $display("FAIL stall_pre: got %0h want 5", dec_pc); end
    dec_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'd5 || rom_ra !== 8'd6 || dec_inst !== rom[5]) begin
        n_fail++; $display("FAIL stall_hold_%0d: got vld=%0b pc=%0h ra=%0h want vld=1 pc=5 ra=6", i, dec_vld, dec_pc, rom_ra);
      end
    end
    dec_rdy = 1'b1;
    step();
    n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'd6 || dec_inst !== rom[6]) begin
      n_fail++; $display("FAIL stall_release: got vld=%0b pc=%0h want vld=1 pc=6", dec_vld, dec_pc);
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; dec_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (dec_pc !== 8'd3) begin n_fail++; $display("FAIL redir_pre: got %0h want 3", dec_pc); end
    redirect_vld = 1'b1; redirect_pc = 8'd32;
    step();
    redirect_vld = 1'b0;
    n_checks++; if (dec_vld !== 1'b0 || rom_ra !== 8'd32 || stat_redirect !== 16'd1) begin
      n_fail++; $display("FAIL redir_t1: got vld=%0b ra=%0h stat=%0d want vld=0 ra=20 stat=1", dec_vld, rom_ra, stat_redirect);
    end
    step();
    n_checks++; if (dec_vld !== 1'b0 || rom_ra !== 8'd32) begin
      n_fail++; $display("FAIL redir_bubble: got vld=%0b ra=%0h want vld=0 ra=20", dec_vld, rom_ra);
    end
    step();
    n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'd32 || dec_inst !== rom[32]) begin
      n_fail++; $display("FAIL redir_target: got vld=%0b pc=%0h want vld=1 pc=20", dec_vld, dec_pc);
    end
    step();
    n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'd33) begin
      n_fail++; $display("FAIL redir_next: got vld=%0b pc=%0h want vld=1 pc=21", dec_vld, dec_pc);
    end
    $display("test_redirect done");
  endtask

  task automatic test_squash();
    redirect_vld = 1'b1; redirect_pc = 8'd9;
    step();
    redirect_vld = 1'b0;
    step(); step();
    n_checks++; if (dec_pc !== 8'd9 || dec_vld !== 1'b1) begin n_fail++; $display("FAIL squash_pre: got pc=%0h vld=%0b want pc=9 vld=1", dec_pc, dec_vld); end
    dec_rdy = 1'b0; redirect_vld = 1'b1; redirect_pc = 8'd96;
    step();
    redirect_vld = 1'b0;
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL squash_drop: got vld=%0b want 0", dec_vld); end
    step();
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL squash_bubble: got vld=%0b want 0", dec_vld); end
    step();
    n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'd96 || stat_redirect !== 16'd3) begin
      n_fail++; $display("FAIL squash_target: got vld=%0b pc=%0h stat=%0d want vld=1 pc=60 stat=3", dec_vld, dec_pc, stat_redirect);
    end
    dec_rdy = 1'b1;
    $display("test_squash done");
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    redirect_vld = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect_vld = 1'b0;
    step();
    exp_pc = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (dec_vld !== 1'b1 || dec_pc !== exp_pc || dec_inst !== rom[exp_pc]) begin
        n_fail++; $display("FAIL wrap_%0d: got vld=%0b pc=%0h want vld=1 pc=%0h", i, dec_vld, dec_pc, exp_pc);
      end
      exp_pc = exp_pc + 8'd1;
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_in_redir();
    redirect_vld = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; fetch_en = 1'b0;
    n_checks++; if (dec_vld !== 1'b0 || dec_pc !== 8'd0 || dec_inst !== 16'd0 || stat_redirect !== 16'd0 || rom_ra !== 8'd0) begin
      n_fail++; $display("FAIL rst_redir: got vld=%0b pc=%0h inst=%0h stat=%0d ra=%0h want all 0",
                         dec_vld, dec_pc, dec_inst, stat_redirect, rom_ra);
    end
    step(); step();
    n_checks++; if (dec_vld !== 1'b0 || rom_ra !== 8'd0) begin
      n_fail++; $display("FAIL rst_idle: got vld=%0b ra=%0h want vld=0 ra=0", dec_vld, rom_ra);
    end
    fetch_en = 1'b1;
    step();
    n_checks++; if (dec_vld !== 1'b1 || dec_pc !== 8'd0 || dec_inst !== rom[0]) begin
      n_fail++; $display("FAIL rst_refetch: got vld=%0b pc=%0h want vld=1 pc=0", dec_vld, dec_pc);
    end
    $display("test_reset_in_redir done");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      fetch_en     = ($urandom_range(0, 9) < 8);
      dec_rdy      = ($urandom_range(0, 9) < 7);
      redirect_vld = ($urandom_range(0, 9) == 0);
      redirect_pc  = 8'($urandom);
      step();
      n_checks++;
      if (dec_vld !== m_vld || rom_ra !== m_pc || stat_redirect !== m_cnt ||
          (m_vld && (dec_pc !== m_dpc || dec_inst !== m_inst))) begin
        n_fail++;
        $display("FAIL random_%0d: got vld=%0b pc=%0h inst=%0h ra=%0h stat=%0d want vld=%0b pc=%0h inst=%0h ra=%0h stat=%0d",
                 i, dec_vld, dec_pc, dec_inst, rom_ra, stat_redirect, m_vld, m_dpc, m_inst, m_pc, m_cnt);
      end
    end
    rst = 1'b0; redirect_vld = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
    m_pc = 8'd0; m_vld = 1'b0; m_inst = 16'd0; m_dpc = 8'd0;
    m_cnt = 16'd0; m_started = 1'b0; m_bubble = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_squash();
    test_wrap();
    test_reset_in_redir();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
